// File: rtl/ssram_port_arbiter_if.sv
// Requester and SRAM-port signals of the two-requester SRAM port arbiter.
interface ssram_port_arbiter_if #(
    parameter int unsigned BITWIDTH = 32,
    parameter int unsigned AW       = 9
);
    // requester 0 (DMA bus engine) and requester 1 (custom-instruction side)
    logic                request0;
    logic                request1;
    logic                lock0;
    logic                lock1;
    logic                write_enable0;
    logic                write_enable1;
    logic [AW-1:0]       address0;
    logic [AW-1:0]       address1;
    logic [BITWIDTH-1:0] data_in0;
    logic [BITWIDTH-1:0] data_in1;

    // responses to the requesters
    logic                grant0_c;
    logic                grant1_c;
    logic                read_valid0;
    logic                read_valid1;
    logic [BITWIDTH-1:0] read_data_c;

    // shared SRAM port
    logic                ram_write_enable_c;
    logic [AW-1:0]       ram_address_c;
    logic [BITWIDTH-1:0] ram_data_in_c;
    logic [BITWIDTH-1:0] ram_data_out;

    // arbiter side
    modport slave (
        input  request0, request1, lock0, lock1,
        input  write_enable0, write_enable1,
        input  address0, address1, data_in0, data_in1,
        input  ram_data_out,
        output grant0_c, grant1_c, read_valid0, read_valid1, read_data_c,
        output ram_write_enable_c, ram_address_c, ram_data_in_c
    );

    // requesters plus SRAM side
    modport master (
        output request0, request1, lock0, lock1,
        output write_enable0, write_enable1,
        output address0, address1, data_in0, data_in1,
        output ram_data_out,
        input  grant0_c, grant1_c, read_valid0, read_valid1, read_data_c,
        input  ram_write_enable_c, ram_address_c, ram_data_in_c
    );
endinterface

// File: rtl/ssram_port_arbiter.sv
// Round-robin arbiter with bounded burst locking for one synchronous SRAM port.
module ssram_port_arbiter #(
    parameter int unsigned BITWIDTH      = 32,
    parameter int unsigned NR_OF_ENTRIES = 512,
    parameter int unsigned MAX_BURST     = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    ssram_port_arbiter_if.slave    bus
);
    localparam int unsigned AW  = $clog2(NR_OF_ENTRIES);
    localparam int unsigned BCW = $clog2(MAX_BURST) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic           last_grant_q, last_grant_d;
    logic [BCW-1:0] burst_count_q, burst_count_d;
    logic [1:0]     read_pending_q, read_pending_d;

    logic grant0, grant1;
    logic any_grant;
    logic win_lock;

    // Same-cycle grant decision; reset masks every grant
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.request0 && bus.request1) begin
                    grant0 = last_grant_q;
                    grant1 = ~last_grant_q;
                end else begin
                    grant0 = bus.request0;
                    grant1 = bus.request1;
                end
            end
            ST_LOCK0: grant0 = bus.request0;
            ST_LOCK1: grant1 = bus.request1;
            default: begin
                grant0 = 1'b0;
                grant1 = 1'b0;
            end
        endcase
        if (rst_i) begin
            grant0 = 1'b0;
            grant1 = 1'b0;
        end
    end

    assign any_grant = grant0 | grant1;
    assign win_lock  = grant1 ? bus.lock1 : (grant0 & bus.lock0);

    // Next state: lock entry/exit, burst counting, read tracking
    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        burst_count_d  = burst_count_q;
        read_pending_d = {grant1 & ~bus.write_enable1, grant0 & ~bus.write_enable0};

        if (any_grant) begin
            last_grant_d = grant1;
        end

        case (state_q)
            ST_IDLE: begin
                if (any_grant && win_lock) begin
                    state_d       = grant1 ? ST_LOCK1 : ST_LOCK0;
                    burst_count_d = BCW'(1);
                end
            end
            ST_LOCK0, ST_LOCK1: begin
                // release on dropped request, unlocked grant, or the last allowed burst cycle
                if (!any_grant || !win_lock || (burst_count_q == BCW'(MAX_BURST - 1))) begin
                    state_d       = ST_IDLE;
                    burst_count_d = '0;
                end else begin
                    burst_count_d = burst_count_q + BCW'(1);
                end
            end
            default: begin
                state_d       = ST_IDLE;
                burst_count_d = '0;
            end
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= ST_IDLE;
            last_grant_q   <= 1'b1;
            burst_count_q  <= '0;
            read_pending_q <= '0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            burst_count_q  <= burst_count_d;
            read_pending_q <= read_pending_d;
        end
    end

    // SRAM port mux; ungranted cycles park on requester 0 with writes disabled
    assign bus.ram_write_enable_c = (grant0 & bus.write_enable0) | (grant1 & bus.write_enable1);
    assign bus.ram_address_c      = grant1 ? bus.address1 : bus.address0;
    assign bus.ram_data_in_c      = grant1 ? bus.data_in1 : bus.data_in0;

    assign bus.grant0_c    = grant0;
    assign bus.grant1_c    = grant1;
    assign bus.read_valid0 = read_pending_q[0];
    assign bus.read_valid1 = read_pending_q[1];
    assign bus.read_data_c = bus.ram_data_out;
endmodule

// File: tb/tb_ssram_port_arbiter.sv
// Bench for ssram_port_arbiter: directed scenarios plus random traffic against a reference model.
module tb_ssram_port_arbiter;
    localparam int unsigned BW    = 32;
    localparam int unsigned DEPTH = 512;
    localparam int unsigned AW    = 9;
    localparam int          MAXB  = 4;

    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;

    ssram_port_arbiter_if #(.BITWIDTH(BW), .AW(AW)) bus ();

    ssram_port_arbiter #(
        .BITWIDTH     (BW),
        .NR_OF_ENTRIES(DEPTH),
        .MAX_BURST    (MAXB)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural SRAM on the arbitrated port, 1-cycle registered read
    logic [BW-1:0] sram [DEPTH];
    always @(posedge clk) begin
        if (bus.ram_write_enable_c) sram[bus.ram_address_c] <= bus.ram_data_in_c;
        bus.ram_data_out <= sram[bus.ram_address_c];
    end

    function automatic logic [BW-1:0] init_word(int i);
        return (32'(i) * 32'h0101_0101) ^ 32'h5EED_0000;
    endfunction

    // reference model: lock owner (-1 none), granted cycles in current lock, last winner
    int            m_owner;
    int            m_run;
    int            m_last;
    logic [BW-1:0] m_mem [DEPTH];
    logic          m_rv0;
    logic          m_rv1;
    logic [BW-1:0] m_rd;

    task automatic model_reset();
        m_owner = -1;
        m_run   = 0;
        m_last  = 1;
        m_rv0   = 1'b0;
        m_rv1   = 1'b0;
    endtask

    function automatic int predict();
        if (rst) return -1;
        if (m_owner == 0) return bus.request0 ? 0 : -1;
        if (m_owner == 1) return bus.request1 ? 1 : -1;
        if (bus.request0 && bus.request1) return (m_last == 0) ? 1 : 0;
        if (bus.request0) return 0;
        if (bus.request1) return 1;
        return -1;
    endfunction

    // apply the current cycle's inputs to the model at the clock edge
    task automatic commit();
        int            g;
        logic          lk;
        logic          we;
        logic [AW-1:0] a;
        logic [BW-1:0] d;
        g = predict();
        if (rst) begin
            model_reset();
            return;
        end
        m_rv0 = 1'b0;
        m_rv1 = 1'b0;
        lk    = 1'b0;
        if (g >= 0) begin
            lk = (g == 1) ? bus.lock1 : bus.lock0;
            we = (g == 1) ? bus.write_enable1 : bus.write_enable0;
            a  = (g == 1) ? bus.address1 : bus.address0;
            d  = (g == 1) ? bus.data_in1 : bus.data_in0;
            if (we) m_mem[a] = d;
            else begin
                m_rd = m_mem[a];
                if (g == 1) m_rv1 = 1'b1; else m_rv0 = 1'b1;
            end
            m_last = g;
        end
        if (m_owner >= 0) begin
            if (g < 0 || !lk) m_owner = -1;
            else begin
                m_run++;
                if (m_run >= MAXB) m_owner = -1;
            end
        end else if (g >= 0 && lk) begin
            m_owner = g;
            m_run   = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        commit();
        @(negedge clk);
    endtask

    task automatic set_in(input logic r0, input logic r1, input logic l0, input logic l1,
                          input logic w0, input logic w1, input int a0, input int a1,
                          input logic [BW-1:0] d0, input logic [BW-1:0] d1);
        bus.request0      = r0;
        bus.request1      = r1;
        bus.lock0         = l0;
        bus.lock1         = l1;
        bus.write_enable0 = w0;
        bus.write_enable1 = w1;
        bus.address0      = AW'(a0);
        bus.address1      = AW'(a1);
        bus.data_in0      = d0;
        bus.data_in1      = d1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        set_in(1, 1, 1, 1, 1, 1, 3, 4, 32'h1111_1111, 32'h2222_2222);
        for (int c = 0; c < 2; c++) begin
            #1;
            n_total++; if (bus.grant0_c !== 1'b0) $display("FAIL reset_grant0: got %b want 0", bus.grant0_c); else n_pass++;
            n_total++; if (bus.grant1_c !== 1'b0) $display("FAIL reset_grant1: got %b want 0", bus.grant1_c); else n_pass++;
            n_total++; if (bus.ram_write_enable_c !== 1'b0) $display("FAIL reset_ram_we: got %b want 0", bus.ram_write_enable_c); else n_pass++;
            n_total++; if ({bus.read_valid1, bus.read_valid0} !== 2'b00) $display("FAIL reset_read_valid: got %b want 00", {bus.read_valid1, bus.read_valid0}); else n_pass++;
            tick();
        end
        n_total++; if (sram[3] !== init_word(3)) $display("FAIL reset_no_write: got %h want %h", sram[3], init_word(3)); else n_pass++;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, '0, '0);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        int exp_g [5] = '{0, 1, 0, 1, -1};
        for (int c = 0; c < 5; c++) begin
            if (c < 4) set_in(1, 1, 0, 0, 0, 0, 5, 9, '0, '0);
            else       set_in(0, 0, 0, 0, 0, 0, 0, 0, '0, '0);
            #1;
            n_total++;
            if ({bus.grant1_c, bus.grant0_c} !== {exp_g[c] == 1, exp_g[c] == 0})
                $display("FAIL rr_grant c%0d: got %b want winner %0d", c, {bus.grant1_c, bus.grant0_c}, exp_g[c]);
            else n_pass++;
            if (c > 0) begin
                n_total++;
                if ({bus.read_valid1, bus.read_valid0} !== {exp_g[c-1] == 1, exp_g[c-1] == 0})
                    $display("FAIL rr_read_valid c%0d: got %b want from %0d", c, {bus.read_valid1, bus.read_valid0}, exp_g[c-1]);
                else n_pass++;
                n_total++;
                if (bus.read_data_c !== init_word(exp_g[c-1] == 1 ? 9 : 5))
                    $display("FAIL rr_read_data c%0d: got %h want %h", c, bus.read_data_c, init_word(exp_g[c-1] == 1 ? 9 : 5));
                else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_write_then_read();
        set_in(1, 0, 0, 0, 1, 0, 3, 0, 32'hA5A5_A5A5, '0);
        #1;
        n_total++; if (!(bus.grant0_c === 1'b1 && bus.ram_write_enable_c === 1'b1 && bus.ram_address_c === AW'(3) && bus.ram_data_in_c === 32'hA5A5_A5A5))
            $display("FAIL wr_port: got g0=%b we=%b a=%0d d=%h want 1 1 3 a5a5a5a5", bus.grant0_c, bus.ram_write_enable_c, bus.ram_address_c, bus.ram_data_in_c);
        else n_pass++;
        tick();
        set_in(0, 1, 0, 0, 0, 0, 0, 3, '0, '0);
        #1;
        n_total++; if (!(bus.grant1_c === 1'b1 && bus.ram_write_enable_c === 1'b0 && bus.ram_address_c === AW'(3)))
            $display("FAIL rd_port: got g1=%b we=%b a=%0d want 1 0 3", bus.grant1_c, bus.ram_write_enable_c, bus.ram_address_c);
        else n_pass++;
        n_total++; if (bus.read_valid0 !== 1'b0) $display("FAIL wr_no_valid: got %b want 0", bus.read_valid0); else n_pass++;
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, '0, '0);
        #1;
        n_total++; if ({bus.read_valid1, bus.read_valid0} !== 2'b10) $display("FAIL raw_valid: got %b want 10", {bus.read_valid1, bus.read_valid0}); else n_pass++;
        n_total++; if (bus.read_data_c !== 32'hA5A5_A5A5) $display("FAIL raw_data: got %h want a5a5a5a5", bus.read_data_c); else n_pass++;
        tick();
    endtask

    task automatic test_burst_limit();
        int exp_g [7] = '{0, 0, 0, 0, 1, 0, -1};
        for (int c = 0; c < 7; c++) begin
            if (c < 6) set_in(1, 1, 1, 0, 0, 0, 2, 7, '0, '0);
            else       set_in(0, 0, 0, 0, 0, 0, 0, 0, '0, '0);
            #1;
            n_total++;
            if ({bus.grant1_c, bus.grant0_c} !== {exp_g[c] == 1, exp_g[c] == 0})
                $display("FAIL burst_grant c%0d: got %b want winner %0d", c + 1, {bus.grant1_c, bus.grant0_c}, exp_g[c]);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_lock_drop();
        int exp_g [3] = '{1, -1, 0};
        for (int c = 0; c < 3; c++) begin
            case (c)
                0:       set_in(0, 1, 0, 1, 0, 0, 1, 6, '0, '0);
                1:       set_in(1, 0, 0, 1, 1, 0, 1, 6, 32'hDEAD_BEEF, '0);
                default: set_in(1, 0, 0, 0, 0, 0, 1, 6, '0, '0);
            endcase
            #1;
            n_total++;
            if ({bus.grant1_c, bus.grant0_c} !== {exp_g[c] == 1, exp_g[c] == 0})
                $display("FAIL drop_grant c%0d: got %b want winner %0d", c + 1, {bus.grant1_c, bus.grant0_c}, exp_g[c]);
            else n_pass++;
            if (c == 1) begin
                n_total++; if (bus.ram_write_enable_c !== 1'b0) $display("FAIL drop_no_write: got %b want 0", bus.ram_write_enable_c); else n_pass++;
            end
            tick();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, '0, '0);
        tick();
    endtask

    task automatic test_reset_mid_burst();
        set_in(1, 0, 1, 0, 0, 0, 11, 12, '0, '0);
        tick();
        set_in(1, 1, 1, 0, 0, 0, 11, 12, '0, '0);
        #1;
        n_total++; if (bus.grant0_c !== 1'b1) $display("FAIL midrst_locked: got %b want 1", bus.grant0_c); else n_pass++;
        tick();
        n_total++; if (bus.read_valid0 !== 1'b1) $display("FAIL midrst_pending: got %b want 1", bus.read_valid0); else n_pass++;
        rst = 1'b1;
        model_reset();
        set_in(1, 1, 1, 1, 1, 1, 11, 12, 32'hBAD0_BAD0, 32'hBAD1_BAD1);
        #1;
        n_total++; if ({bus.grant1_c, bus.grant0_c} !== 2'b00) $display("FAIL midrst_grants: got %b want 00", {bus.grant1_c, bus.grant0_c}); else n_pass++;
        n_total++; if ({bus.read_valid1, bus.read_valid0} !== 2'b00) $display("FAIL midrst_valid: got %b want 00", {bus.read_valid1, bus.read_valid0}); else n_pass++;
        n_total++; if (bus.ram_write_enable_c !== 1'b0) $display("FAIL midrst_we: got %b want 0", bus.ram_write_enable_c); else n_pass++;
        tick();
        n_total++; if (sram[11] !== m_mem[11]) $display("FAIL midrst_mem: got %h want %h", sram[11], m_mem[11]); else n_pass++;
        rst = 1'b0;
        set_in(1, 1, 0, 0, 0, 0, 11, 12, '0, '0);
        #1;
        n_total++; if ({bus.grant1_c, bus.grant0_c} !== 2'b01) $display("FAIL midrst_first_tie: got %b want 01", {bus.grant1_c, bus.grant0_c}); else n_pass++;
        tick();
    endtask

    task automatic test_random();
        int g;
        logic [AW-1:0] ea;
        for (int c = 0; c < 400; c++) begin
            set_in(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                   1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   $urandom, $urandom);
            #1;
            g = predict();
            n_total++;
            if ({bus.grant1_c, bus.grant0_c} !== {g == 1, g == 0})
                $display("FAIL rand_grant c%0d: got %b want winner %0d", c, {bus.grant1_c, bus.grant0_c}, g);
            else n_pass++;
            if (g >= 0) begin
                ea = (g == 1) ? bus.address1 : bus.address0;
                n_total++;
                if (bus.ram_address_c !== ea || bus.ram_write_enable_c !== ((g == 1) ? bus.write_enable1 : bus.write_enable0))
                    $display("FAIL rand_port c%0d: got a=%0d we=%b want a=%0d", c, bus.ram_address_c, bus.ram_write_enable_c, ea);
                else n_pass++;
            end else begin
                n_total++; if (bus.ram_write_enable_c !== 1'b0) $display("FAIL rand_idle_we c%0d: got %b want 0", c, bus.ram_write_enable_c); else n_pass++;
            end
            n_total++;
            if ({bus.read_valid1, bus.read_valid0} !== {m_rv1, m_rv0})
                $display("FAIL rand_valid c%0d: got %b want %b", c, {bus.read_valid1, bus.read_valid0}, {m_rv1, m_rv0});
            else n_pass++;
            if (m_rv0 || m_rv1) begin
                n_total++; if (bus.read_data_c !== m_rd) $display("FAIL rand_data c%0d: got %h want %h", c, bus.read_data_c, m_rd); else n_pass++;
            end
            tick();
        end
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst     = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            sram[i]  = init_word(i);
            m_mem[i] = init_word(i);
        end
        model_reset();
        m_rd = '0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, '0, '0);
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_write_then_read();
        test_burst_limit();
        test_lock_drop();
        test_reset_mid_burst();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
